// File: rtl/data_memory_sync.sv
// data_memory_sync: clocked data memory for the MEM stage.
// Byte-enabled synchronous writes, registered one-cycle read with a valid
// strobe, an optional post-reset clearing sweep gated by Ready, selectable
// read-during-write ordering and an out-of-range address error pulse.
module data_memory_sync #(
    parameter int DATA_WIDTH     = 16,
    parameter int SIZE           = 256,
    parameter int ADDR_WIDTH     = 16,
    parameter int CLEAR_ON_RESET = 1,
    parameter int WRITE_FIRST    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    MemReadEn,
    input  logic                    MemWriteEn,
    input  logic [DATA_WIDTH/8-1:0] ByteEn,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   writeData,
    output logic [DATA_WIDTH-1:0]   ReadData,
    output logic                    ReadValid,
    output logic                    Ready,
    output logic                    AddrError
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    // One extra bit so SIZE itself is representable for the range compare.
    localparam logic [ADDR_WIDTH:0] SIZE_EXT = (ADDR_WIDTH + 1)'(SIZE);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(SIZE - 1);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        cnt_q, cnt_d;
    logic                    ready_d;
    logic [DATA_WIDTH-1:0]   rdata_d;
    logic                    rvalid_d;
    logic                    aerr_d;

    logic                    mem_we;
    logic [IDX_W-1:0]        mem_waddr;
    logic [LANES-1:0]        mem_lanes;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem [SIZE];

    logic                    addr_ok;
    logic [IDX_W-1:0]        idx;
    logic [DATA_WIDTH-1:0]   old_word;
    logic [DATA_WIDTH-1:0]   merged_word;

    // Full-width compare: an out-of-range address is never wrapped into range.
    assign addr_ok  = {1'b0, address} < SIZE_EXT;
    assign idx      = address[IDX_W-1:0];
    assign old_word = mem[idx];

    // Word as it will look after this cycle's byte-enabled write.
    // NOTE: combinational blocks use blocking '=' so later statements see
    // earlier updates; clocked blocks use '<=' so all registers update together.
    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (ByteEn[i]) merged_word[8*i +: 8] = writeData[8*i +: 8];
        end
    end

    // Next-state, sweep counter, memory write port and registered outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = Ready;
        rdata_d   = ReadData;
        rvalid_d  = 1'b0;
        aerr_d    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = idx;
        mem_lanes = ByteEn;
        mem_wdata = writeData;

        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_lanes = '1;
                mem_wdata = '0;
                cnt_d     = cnt_q + IDX_W'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                ready_d = 1'b1;
                // Requests are accepted only once Ready has been presented.
                if (Ready) begin
                    if (MemWriteEn && addr_ok) mem_we = 1'b1;
                    if (MemReadEn) begin
                        rvalid_d = 1'b1;
                        if (!addr_ok)                          rdata_d = '0;
                        else if (WRITE_FIRST != 0 && MemWriteEn) rdata_d = merged_word;
                        else                                   rdata_d = old_word;
                    end
                    if ((MemReadEn || MemWriteEn) && !addr_ok) aerr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            cnt_q     <= '0;
            Ready     <= 1'b0;
            ReadData  <= '0;
            ReadValid <= 1'b0;
            AddrError <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            Ready     <= ready_d;
            ReadData  <= rdata_d;
            ReadValid <= rvalid_d;
            AddrError <= aerr_d;
        end
    end

    // Storage array: clearing is done by the sweep, not by reset.
    // NOTE: the array has no reset branch so it maps onto RAM; a reset here
    // would force every word into flip-flops.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (mem_lanes[i]) mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_memory_sync.sv
// Self-checking bench for data_memory_sync: three instances share stimulus
// (default, WRITE_FIRST=0, CLEAR_ON_RESET=0); table vectors plus sequences
// for the reset sweep, mid-sweep reset and contents-preserving reset.
module tb_data_memory_sync;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadEn, MemWriteEn;
    logic [1:0]  ByteEn;
    logic [15:0] address, writeData;

    logic [15:0] rdata_a, rdata_b, rdata_c;
    logic        rvalid_a, rvalid_b, rvalid_c;
    logic        ready_a, ready_b, ready_c;
    logic        aerr_a, aerr_b, aerr_c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_memory_sync dut_a (
        .clk(clk), .reset(reset), .MemReadEn(MemReadEn), .MemWriteEn(MemWriteEn),
        .ByteEn(ByteEn), .address(address), .writeData(writeData),
        .ReadData(rdata_a), .ReadValid(rvalid_a), .Ready(ready_a), .AddrError(aerr_a)
    );

    data_memory_sync #(.WRITE_FIRST(0)) dut_b (
        .clk(clk), .reset(reset), .MemReadEn(MemReadEn), .MemWriteEn(MemWriteEn),
        .ByteEn(ByteEn), .address(address), .writeData(writeData),
        .ReadData(rdata_b), .ReadValid(rvalid_b), .Ready(ready_b), .AddrError(aerr_b)
    );

    data_memory_sync #(.CLEAR_ON_RESET(0)) dut_c (
        .clk(clk), .reset(reset), .MemReadEn(MemReadEn), .MemWriteEn(MemWriteEn),
        .ByteEn(ByteEn), .address(address), .writeData(writeData),
        .ReadData(rdata_c), .ReadValid(rvalid_c), .Ready(ready_c), .AddrError(aerr_c)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  be;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        exp_valid;
        logic [15:0] exp_data;     // WRITE_FIRST=1 instance
        logic [15:0] exp_data_wf0; // WRITE_FIRST=0 instance
        logic        exp_err;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] be,
                         input logic [15:0] addr, input logic [15:0] wd);
        MemReadEn  = rd;
        MemWriteEn = wr;
        ByteEn     = be;
        address    = addr;
        writeData  = wd;
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] be,
                                input logic [15:0] addr, input logic [15:0] wd,
                                input logic ev, input logic [15:0] ed,
                                input logic [15:0] ed0, input logic ee);
        vec_t v;
        v.rd = rd; v.wr = wr; v.be = be; v.addr = addr; v.wdata = wd;
        v.exp_valid = ev; v.exp_data = ed; v.exp_data_wf0 = ed0; v.exp_err = ee;
        return v;
    endfunction

    initial begin
        int n;
        int rv_seen;
        int rdy_seen;

        // Post-sweep IDLE vectors; memory starts all zero in dut_a/dut_b.
        vecs[0]  = mk(1, 0, 2'b00, 16'd0,    16'h0000, 1, 16'h0000, 16'h0000, 0);
        vecs[1]  = mk(1, 0, 2'b00, 16'd17,   16'h0000, 1, 16'h0000, 16'h0000, 0);
        vecs[2]  = mk(1, 0, 2'b00, 16'd255,  16'h0000, 1, 16'h0000, 16'h0000, 0);
        vecs[3]  = mk(1, 0, 2'b00, 16'd20,   16'h0000, 1, 16'h0000, 16'h0000, 0);
        vecs[4]  = mk(0, 1, 2'b11, 16'd5,    16'hBEEF, 0, 16'h0000, 16'h0000, 0);
        vecs[5]  = mk(0, 1, 2'b01, 16'd5,    16'h1234, 0, 16'h0000, 16'h0000, 0);
        vecs[6]  = mk(1, 0, 2'b00, 16'd5,    16'h0000, 1, 16'hBE34, 16'hBE34, 0);
        vecs[7]  = mk(0, 1, 2'b11, 16'd9,    16'h5555, 0, 16'hBE34, 16'hBE34, 0);
        vecs[8]  = mk(1, 1, 2'b11, 16'd9,    16'hAAAA, 1, 16'hAAAA, 16'h5555, 0);
        vecs[9]  = mk(1, 0, 2'b00, 16'd9,    16'h0000, 1, 16'hAAAA, 16'hAAAA, 0);
        vecs[10] = mk(0, 1, 2'b11, 16'd256,  16'hFFFF, 0, 16'hAAAA, 16'hAAAA, 1);
        vecs[11] = mk(1, 0, 2'b00, 16'd256,  16'h0000, 1, 16'h0000, 16'h0000, 1);
        vecs[12] = mk(1, 0, 2'b00, 16'd0,    16'h0000, 1, 16'h0000, 16'h0000, 0);
        vecs[13] = mk(0, 1, 2'b00, 16'd7,    16'h1111, 0, 16'h0000, 16'h0000, 0);
        vecs[14] = mk(1, 0, 2'b00, 16'd7,    16'h0000, 1, 16'h0000, 16'h0000, 0);
        vecs[15] = mk(1, 1, 2'b10, 16'd7,    16'hABCD, 1, 16'hAB00, 16'h0000, 0);
        vecs[16] = mk(1, 0, 2'b00, 16'd7,    16'h0000, 1, 16'hAB00, 16'hAB00, 0);
        vecs[17] = mk(1, 1, 2'b11, 16'hFFFF, 16'h5A5A, 1, 16'h0000, 16'h0000, 1);
        vecs[18] = mk(1, 0, 2'b00, 16'd255,  16'h0000, 1, 16'h0000, 16'h0000, 0);
        vecs[19] = mk(0, 0, 2'b00, 16'd0,    16'h0000, 0, 16'h0000, 16'h0000, 0);

        // Reset for two cycles.
        reset = 1'b1;
        drive(0, 0, 2'b00, 16'd0, 16'h0000);
        tick();
        tick();
        check("rst_ready",     ready_a,  1'b0);
        check("rst_readvalid", rvalid_a, 1'b0);
        check("rst_readdata",  rdata_a,  16'h0000);
        check("rst_addrerror", aerr_a,   1'b0);
        check("rst_ready_nc",  ready_c,  1'b0);

        // Sweep with requests held active; they must be ignored.
        reset = 1'b0;
        drive(1, 1, 2'b11, 16'd20, 16'hFFFF);
        n = 0;
        rv_seen = 0;
        do begin
            tick();
            n++;
            if (rvalid_a || aerr_a) rv_seen++;
        end while (!ready_a && n < 400);
        check("sweep_len", n, 256);
        check("sweep_no_req", rv_seen, 0);
        drive(0, 0, 2'b00, 16'd0, 16'h0000);

        // Table-driven IDLE vectors.
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].be, vecs[i].addr, vecs[i].wdata);
            tick();
            check($sformatf("v%0d_valid", i),    rvalid_a, vecs[i].exp_valid);
            check($sformatf("v%0d_data", i),     rdata_a,  vecs[i].exp_data);
            check($sformatf("v%0d_data_wf0", i), rdata_b,  vecs[i].exp_data_wf0);
            check($sformatf("v%0d_err", i),      aerr_a,   vecs[i].exp_err);
        end

        // Contents-preserving reset on dut_c.
        drive(0, 1, 2'b11, 16'd3, 16'h0F0F);
        tick();
        drive(0, 0, 2'b00, 16'd0, 16'h0000);
        reset = 1'b1;
        tick();
        check("nc_rst_ready", ready_c, 1'b0);
        reset = 1'b0;
        drive(1, 0, 2'b00, 16'd3, 16'h0000);
        tick();
        check("nc_ready_first_edge", ready_c, 1'b1);
        check("nc_rv_not_ready",     rvalid_c, 1'b0);
        tick();
        check("nc_read_valid", rvalid_c, 1'b1);
        check("nc_read_data",  rdata_c,  16'h0F0F);
        check("sweep_rv_a",    rvalid_a, 1'b0);

        // Continue to sweep cycle 100 with requests active, then re-reset.
        drive(1, 1, 2'b11, 16'd5, 16'h7777);
        rv_seen  = 0;
        rdy_seen = 0;
        for (int c = 2; c < 100; c++) begin
            tick();
            if (rvalid_a || aerr_a) rv_seen++;
            if (ready_a) rdy_seen++;
        end
        check("mid_ready_low", rdy_seen, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
            if (rvalid_a || aerr_a) rv_seen++;
        end while (!ready_a && n < 400);
        check("resweep_len",    n, 256);
        check("resweep_no_req", rv_seen, 0);

        // Sweep cleared addr 5 (was 0xBE34); sweep-time writes were dropped.
        drive(1, 0, 2'b00, 16'd5, 16'h0000);
        tick();
        check("post_clear_valid",    rvalid_a, 1'b1);
        check("post_clear_data",     rdata_a,  16'h0000);
        check("post_clear_data_wf0", rdata_b,  16'h0000);
        drive(0, 0, 2'b00, 16'd0, 16'h0000);
        tick();
        check("idle_valid_low", rvalid_a, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
